seq_player: RTL and testbench
=============================

# seq_player

Playback engine for the step sequencer; the reader side of the beat data model. It consumes the flat `beats` bus produced by the model (4-bit pitch per beat, beat 0 in bits [3:0]) and steps through the beats at a programmable step period. For each beat it emits the beat index, a latched pitch, a one-cycle `note_on` strobe and a half-step `gate` for the downstream tone generator and display.

## Interface
- `NUM_BEATS`, 16, number of beats in the pattern. Must be a power of two, ≥2.
- `PERIOD_W`, 24, width of the step-period input.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `beats`  in  NUM_BEATS*4  pattern from the model; beat i is in bits [i*4 +: 4]; pitch 0 = rest
- `start`  in  1  pulse; begin (or restart) playback at beat 0
- `stop`  in  1  pulse; halt playback
- `step_period`  in  PERIOD_W  clock cycles per beat; values <2 are treated as 2
- `playing`  out  1  high while in PLAY
- `beat_index`  out  $clog2(NUM_BEATS)  current beat
- `pitch`  out  4  pitch latched for the current beat
- `note_on`  out  1  one-cycle strobe at the start of a non-rest beat
- `gate`  out  1  high for the first half of a non-rest beat
- `wrap`  out  1  one-cycle strobe when the index wraps from NUM_BEATS-1 to 0

## Operation
- Two states: IDLE and PLAY.
- **Reset:** async to IDLE. All outputs are 0, the step counter is 0 and the latched period is 2.
- **IDLE:** all outputs are held at 0. On `start`, go to PLAY and begin beat 0.
- **Beginning a beat i:**
  - `beat_index`←i.
  - `pitch`←`beats[i*4 +: 4]`.
  - Latch period P = max(`step_period`, 2).
  - Counter←0.
  - `note_on`=1 for one cycle if pitch≠0.
  - `gate`←(pitch≠0).
- **PLAY:** the counter increments every cycle.
  - When counter = P/2−1 (integer divide), `gate` goes low.
  - When counter = P−1, begin beat (i+1) mod NUM_BEATS.
  - If the new index is 0 (wrap), `wrap`=1 for that cycle.
- **Pitch and period are sampled only at beat start.** Changes to `beats` or `step_period` mid-beat do not affect the current beat.
- **Repeated pitches:** consecutive identical non-rest pitches each produce their own `note_on`.
- **Rest beat:** `pitch` is 0, there is no `note_on`, and `gate` stays 0.
- **`start` in PLAY:** restart at beat 0 on the next edge. `wrap` is not asserted on a restart.
- **`stop` in any state:** go to IDLE on the next edge; all outputs are 0.
- **`start` and `stop` in the same cycle:** `stop` wins.
- **`rst_n` low mid-beat:** outputs clear immediately (async). After release, the block is in IDLE and waits for `start`.

## Timing
- `start` sampled at edge N: `playing`, `beat_index`=0, `pitch` and `note_on` are valid after edge N.
- Each beat lasts exactly P cycles. `note_on` is the first cycle of the beat.
- `gate` is high for exactly floor(P/2) cycles. With P=2, `gate` is high for 1 cycle.
- `stop` sampled at edge N: all outputs are 0 after edge N. A `note_on` coinciding with that edge is suppressed.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Package `seq_pkg`:**
  - `NUM_BEATS` default.
  - `PITCH_W`=4.
  - `PITCH_REST`=4'd0.
  - State enum `player_state_t` {IDLE, PLAY}.
  - Shared with the model and the tone generator.
- **Sub-module `step_timer`:**
  - Loadable cycle counter.
  - Inputs: `load`, `period`.
  - Outputs: `half_done` and `step_done` strobes.
- **Top level:** `seq_player` holds the FSM, the index counter and the output registers.

## Test plan
- **Basic playback:** reset; beats = pitch 3 on beat 0, 7 on beat 1, rest elsewhere; `step_period`=8; `start`.
  - Required: `note_on` at cycles 1 and 9 with pitch 3 then 7.
  - `gate` high for cycles 1–4 and 9–12.
  - No `note_on` for beats 2–15.
- **Wrap:** `step_period`=4, NUM_BEATS=16.
  - Required: `wrap` pulses once every 64 cycles, on the cycle `beat_index` returns to 0.
  - `note_on` for beat 0 recurs.
- **Mid-beat edit:** change beat 2 from 0 to 5 during beat 2.
  - Required: beat 2 stays a rest this lap.
  - `note_on` with pitch 5 on the next lap.
- **Control collisions:**
  - `start` during beat 6 → next cycle `beat_index`=0 and `note_on`, with no `wrap`.
  - `start` and `stop` together → IDLE with all outputs 0.
- **Period edge cases:**
  - `step_period`=0 → 2-cycle beats with `gate` high for 1 cycle.
  - Changing `step_period` from 8 to 16 mid-beat → the current beat still lasts 8 cycles and the next beat lasts 16.
- **Async reset:** assert `rst_n` low mid-gate.
  - Required: all outputs are 0 before the next edge.
  - After release, the block stays idle until `start`.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared step-sequencer types and constants (model, player, tone generator).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

  localparam int NUM_BEATS_DEFAULT = 16;
  localparam int PITCH_W           = 4;

  localparam logic [PITCH_W-1:0] PITCH_REST = 4'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } player_state_t;

  // A beat sounds only when its pitch is not the rest code.
  function automatic logic is_note(input logic [PITCH_W-1:0] p);
    return p != PITCH_REST;
  endfunction

endpackage

// File: rtl/seq_player_if.sv
// Control/pattern inputs and playback outputs of the sequencer player.
// Latency: n/a (wires only).
// Backpressure: none; start/stop are pulses, note_on/wrap are one-cycle strobes.
//
// master : drives beats, start, stop, step_period; observes playback outputs
// slave  : the player; consumes the controls, drives playing/beat_index/pitch/note_on/gate/wrap
interface seq_player_if
  import seq_pkg::*;
#(
  parameter int NUM_BEATS = NUM_BEATS_DEFAULT,
  parameter int PERIOD_W  = 24
);

  localparam int IDX_W = $clog2(NUM_BEATS);

  logic [NUM_BEATS*PITCH_W-1:0] beats;
  logic                         start;
  logic                         stop;
  logic [PERIOD_W-1:0]          step_period;

  logic                         playing;
  logic [IDX_W-1:0]             beat_index;
  logic [PITCH_W-1:0]           pitch;
  logic                         note_on;
  logic                         gate;
  logic                         wrap;

  modport master (
    output beats, start, stop, step_period,
    input  playing, beat_index, pitch, note_on, gate, wrap
  );

  modport slave (
    input  beats, start, stop, step_period,
    output playing, beat_index, pitch, note_on, gate, wrap
  );

endinterface

// File: rtl/step_timer.sv
// Loadable per-beat cycle counter producing half-step and end-of-step strobes.
// Latency: strobes are decoded from registered state; load takes effect next cycle.
// Backpressure: none.
//
// clk, rst_n : clock, async active-low reset
// load       : restart the count at 0 and latch max(period, 2)
// run        : count enable (high while playing)
// period     : requested cycles per beat
// half_done  : count is at floor(P/2)-1
// step_done  : count is at P-1 (last cycle of the beat)
module step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                half_done,
  output logic                step_done
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_clamped;

  // Periods below 2 would make the half-step target negative; floor at 2.
  assign period_clamped = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= PERIOD_W'(2);
    end else if (load) begin
      cnt_q    <= '0;
      period_q <= period_clamped;
    end else if (run) begin
      cnt_q    <= cnt_q + PERIOD_W'(1);
    end
  end

  assign half_done = run && (cnt_q == ((period_q >> 1) - PERIOD_W'(1)));
  assign step_done = run && (cnt_q == (period_q - PERIOD_W'(1)));

endmodule

// File: rtl/seq_player.sv
// Step-sequencer playback: walks the beat pattern at a programmable step period.
// Latency: one cycle from start/beat boundary to registered beat outputs.
// Backpressure: none; outputs are free-running, stop overrides start.
//
// clk, rst_n : clock, async active-low reset
// bus.slave  : beats/start/stop/step_period in;
//              playing/beat_index/pitch/note_on/gate/wrap out (all registered)
module seq_player
  import seq_pkg::*;
#(
  parameter int NUM_BEATS = NUM_BEATS_DEFAULT,
  parameter int PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_player_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BEATS);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_PLAY = 1'(PLAY);

  logic [0:0]         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PITCH_W-1:0] pitch_q;
  logic               note_on_q;
  logic               gate_q;
  logic               wrap_q;

  logic               in_play;
  logic               half_done;
  logic               step_done;
  logic               load_beat;
  logic [IDX_W-1:0]   next_idx;
  logic [PITCH_W-1:0] next_pitch;
  logic [PITCH_W-1:0] beat_pitch [NUM_BEATS];

  for (genvar g = 0; g < NUM_BEATS; g++) begin : g_unpack
    assign beat_pitch[g] = bus.beats[g*PITCH_W +: PITCH_W];
  end

  assign in_play = (state_q == ST_PLAY);

  // A new beat begins on start (from either state) or at the end of the
  // current beat; stop suppresses both, including a coincident note_on.
  assign load_beat = !bus.stop && (bus.start || (in_play && step_done));

  // NUM_BEATS is a power of two, so the index wraps by plain overflow.
  assign next_idx   = bus.start ? '0 : (idx_q + IDX_W'(1));
  assign next_pitch = beat_pitch[next_idx];

  step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_beat),
    .run       (in_play),
    .period    (bus.step_period),
    .half_done (half_done),
    .step_done (step_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pitch_q   <= '0;
      note_on_q <= 1'b0;
      gate_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (bus.stop || (!bus.start && !in_play)) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pitch_q   <= '0;
      note_on_q <= 1'b0;
      gate_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (load_beat) begin
      state_q   <= ST_PLAY;
      idx_q     <= next_idx;
      pitch_q   <= next_pitch;
      note_on_q <= is_note(next_pitch);
      gate_q    <= is_note(next_pitch);
      // A restart lands on beat 0 too, but it is not a lap wrap.
      wrap_q    <= !bus.start && (next_idx == '0);
    end else begin
      note_on_q <= 1'b0;
      wrap_q    <= 1'b0;
      if (half_done) begin
        gate_q  <= 1'b0;
      end
    end
  end

  assign bus.playing    = in_play;
  assign bus.beat_index = idx_q;
  assign bus.pitch      = pitch_q;
  assign bus.note_on    = note_on_q;
  assign bus.gate       = gate_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: directed scenarios plus random control,
// all compared cycle by cycle against a time-based reference model.
module tb_seq_player;
  import seq_pkg::*;

  localparam int NB = 16;
  localparam int PW = 24;
  localparam int IW = $clog2(NB);
  localparam int OW = 1 + IW + 4 + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  seq_player_if #(.NUM_BEATS(NB), .PERIOD_W(PW)) bus ();

  seq_player #(.NUM_BEATS(NB), .PERIOD_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt_note, cnt_wrap, cnt_gate;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a beat is described by its start (m_t = cycles since
  // start), its sampled pitch and period; outputs follow from elapsed time.
  bit          m_play, m_wrap;
  int unsigned m_idx, m_pitch, m_p, m_t;

  function automatic int unsigned beat_of(input int unsigned i);
    logic [NB*4-1:0] b;
    b = bus.beats;
    return int'(b[i*4 +: 4]);
  endfunction

  task automatic begin_beat(input int unsigned i, input bit restart);
    m_play  = 1'b1;
    m_idx   = i;
    m_pitch = beat_of(i);
    m_p     = (bus.step_period < 2) ? 2 : int'(bus.step_period);
    m_t     = 0;
    m_wrap  = !restart && (i == 0);
  endtask

  task automatic model_edge();
    if (!rst_n || bus.stop) m_play = 1'b0;
    else if (bus.start) begin_beat(0, 1'b1);
    else if (m_play) begin
      m_t++;
      if (m_t == m_p) begin_beat((m_idx + 1) % NB, 1'b0);
    end
  endtask

  function automatic logic [OW-1:0] exp_outs();
    logic snd;
    if (!m_play) return '0;
    snd = (m_pitch != 0);
    return {1'b1, IW'(m_idx), 4'(m_pitch), snd && (m_t == 0),
            snd && (m_t < m_p / 2), m_wrap && (m_t == 0)};
  endfunction

  function automatic logic [OW-1:0] act_outs();
    return {bus.playing, bus.beat_index, bus.pitch, bus.note_on, bus.gate, bus.wrap};
  endfunction

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("outs", 32'(act_outs()), 32'(exp_outs()));
    cnt_note += int'(bus.note_on);
    cnt_wrap += int'(bus.wrap);
    cnt_gate += int'(bus.gate);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clr_counts();
    cnt_note = 0;
    cnt_wrap = 0;
    cnt_gate = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.beats       = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.step_period = '0;
    m_play          = 1'b0;
    clr_counts();

    rst_n = 1'b0;
    #1 chk("reset", 32'(act_outs()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic playback: pitch 3, 7, then rests; 8-cycle beats.
    bus.beats[3:0]  = 4'd3;
    bus.beats[7:4]  = 4'd7;
    bus.step_period = PW'(8);
    clr_counts();
    pulse_start();
    chk("basic_beat0", {bus.note_on, bus.pitch}, {1'b1, 4'd3});
    repeat (8) tick();
    chk("basic_beat1", {bus.note_on, bus.pitch}, {1'b1, 4'd7});
    repeat (119) tick();
    chk("basic_notes", cnt_note, 2);
    chk("basic_gate", cnt_gate, 8);

    // Wrap: 4-cycle beats, 64-cycle lap.
    bus.step_period = PW'(4);
    pulse_start();
    clr_counts();
    repeat (256) tick();
    chk("wrap_count", cnt_wrap, 4);
    chk("wrap_notes", cnt_note, 8);
    chk("wrap_idx0", {bus.beat_index, bus.wrap}, {4'd0, 1'b1});

    // Mid-beat edit of beat 2.
    repeat (8) tick();
    bus.beats[11:8] = 4'd5;
    tick();
    chk("edit_rest", {bus.beat_index, bus.pitch}, {4'd2, 4'd0});
    repeat (63) tick();
    chk("edit_next_lap", {bus.beat_index, bus.note_on, bus.pitch}, {4'd2, 1'b1, 4'd5});

    // Restart during beat 6.
    repeat (17) tick();
    chk("beat6", bus.beat_index, 6);
    pulse_start();
    chk("restart", {bus.beat_index, bus.note_on, bus.wrap}, {4'd0, 1'b1, 1'b0});

    // start and stop together: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("start_stop", 32'(act_outs()), 32'd0);

    // step_period 0 behaves as 2.
    bus.step_period = '0;
    pulse_start();
    chk("p0_c1", {bus.beat_index, bus.note_on, bus.gate}, {4'd0, 1'b1, 1'b1});
    tick();
    chk("p0_c2", {bus.beat_index, bus.note_on, bus.gate}, {4'd0, 1'b0, 1'b0});
    tick();
    chk("p0_c3", {bus.beat_index, bus.note_on, bus.gate}, {4'd1, 1'b1, 1'b1});

    // Period change 8 -> 16 mid-beat.
    bus.step_period = PW'(8);
    pulse_start();
    repeat (3) tick();
    bus.step_period = PW'(16);
    repeat (4) tick();
    chk("per_c8", bus.beat_index, 0);
    tick();
    chk("per_c9", bus.beat_index, 1);
    repeat (15) tick();
    chk("per_c24", bus.beat_index, 1);
    tick();
    chk("per_c25", bus.beat_index, 2);

    // Async reset mid-gate.
    bus.step_period = PW'(8);
    pulse_start();
    repeat (2) tick();
    chk("pre_reset_gate", bus.gate, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(act_outs()), 32'd0);
    m_play = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset", bus.playing, 0);

    // Random pattern, period, edits and control pulses.
    for (int k = 0; k < NB; k++)
      bus.beats[k*4 +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    bus.step_period = PW'($urandom_range(9));
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      int bi;
      bus.start = ($urandom_range(59) == 0);
      bus.stop  = ($urandom_range(149) == 0);
      if ($urandom_range(19) == 0) bus.step_period = PW'($urandom_range(9));
      if ($urandom_range(9) == 0) begin
        bi = int'($urandom_range(NB - 1));
        bus.beats[bi*4 +: 4] = 4'($urandom_range(15));
      end
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
